// File: rtl/cp0_reg_pkg.sv
// Shared definitions for the coprocessor-0 block.
// Holds the CP0 register numbers, the ExcCode values, the Status and Cause bit
// positions and write masks, the default vector addresses, and the
// ExceptinPipeType layout. It also provides exc_decode(), which turns a
// committing exception vector into ExcCode, BadVAddr source and refill flag.
package cp0_reg_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Status / Cause bit positions
    localparam int STATUS_IE   = 0;
    localparam int STATUS_EXL  = 1;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_TI    = 30;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM, EXL, IE
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;  // IP[1:0]

    localparam logic [31:0] EXC_VECTOR_DEFAULT    = 32'hBFC0_0380;
    localparam logic [31:0] REFILL_VECTOR_DEFAULT = 32'hBFC0_0200;

    // ExceptinPipeType, MSB first
    typedef struct packed {
        logic interrupt;          // 11
        logic wrong_addr_if;      // 10
        logic reserved_instr;     // 9
        logic overflow;           // 8
        logic syscall;            // 7
        logic brk;                // 6
        logic eret;               // 5
        logic rd_wrong_addr_mem;  // 4
        logic wr_wrong_addr_mem;  // 3
        logic tlb_refill;         // 2
        logic tlb_invalid;        // 1
        logic tlb_modified;       // 0
    } except_pipe_t;

    localparam logic [11:0] EXC_TYPE_ERET = 12'h020;

    typedef struct packed {
        logic [4:0] code;
        logic       bv_from_pc;   // BadVAddr <= WB_PC
        logic       bv_from_alu;  // BadVAddr <= WB_ALUOut
        logic       refill;       // winning cause is a TLB refill
    } exc_info_t;

    // Priority encoder over the committing exception bits (Eret ignored here).
    function automatic exc_info_t exc_decode(input except_pipe_t e);
        exc_info_t r;
        r = '0;
        if (e.interrupt) begin
            r.code = EXC_INT;
        end else if (e.wrong_addr_if) begin
            r.code = EXC_ADEL;
            r.bv_from_pc = 1'b1;
        end else if (e.reserved_instr) begin
            r.code = EXC_RI;
        end else if (e.overflow) begin
            r.code = EXC_OV;
        end else if (e.syscall) begin
            r.code = EXC_SYS;
        end else if (e.brk) begin
            r.code = EXC_BP;
        end else if (e.rd_wrong_addr_mem) begin
            r.code = EXC_ADEL;
            r.bv_from_alu = 1'b1;
        end else if (e.wr_wrong_addr_mem) begin
            r.code = EXC_ADES;
            r.bv_from_alu = 1'b1;
        end else if (e.tlb_refill) begin
            r.code = EXC_TLBL;
            r.bv_from_alu = 1'b1;
            r.refill = 1'b1;
        end else if (e.tlb_invalid) begin
            r.code = EXC_TLBL;
            r.bv_from_alu = 1'b1;
        end else if (e.tlb_modified) begin
            r.code = EXC_MOD;
            r.bv_from_alu = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: owns tick, Count, Compare and the timer-interrupt flag TI.
// Ports: clk/rst; wr_en/wr_addr/wr_data carry an already-arbitrated MTC0;
// count/compare/ti expose the current register values.
// Count advances on every cycle where tick=1, so it runs at half the clock rate.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick_reg, tick_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        ti_reg, ti_next;

    always_comb begin
        tick_next    = ~tick_reg;
        count_next   = tick_reg ? count_reg + 32'd1 : count_reg;
        compare_next = compare_reg;
        ti_next      = ti_reg | (count_reg == compare_reg);
        // A software write takes precedence over the increment and the match.
        if (wr_en && wr_addr == CP0_COUNT) begin
            count_next = wr_data;
            ti_next    = ti_reg;
        end
        if (wr_en && wr_addr == CP0_COMPARE) begin
            compare_next = wr_data;
            ti_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg    <= 1'b0;
            count_reg   <= '0;
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else begin
            tick_reg    <= tick_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            ti_reg      <= ti_next;
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file and precise-exception commit unit.
// Inputs: the WB_CP0 stage commit (MTC0 write, exception vector, PC, delay-slot
// flag, data address), level-sensitive ext_int, and an MFC0 read address.
// Outputs: combinational rd_data (with write bypass), cp0_int_req, a registered
// one-cycle exc_flush with exc_pc redirect target, and Status/Cause/EPC.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
    parameter logic [31:0] REFILL_VECTOR = REFILL_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [31:0] WB_Result,
    input  logic [11:0] WB_ExceptType,
    input  logic [31:0] WB_PC,
    input  logic        WB_IsInDelaySlot,
    input  logic [31:0] WB_ALUOut,
    input  logic [5:0]  ext_int,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        cp0_int_req,
    output logic        exc_flush,
    output logic [31:0] exc_pc,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc
);

    logic [31:0] status_reg;
    logic        cause_bd_reg;
    logic [5:0]  cause_ip_hw_reg;   // IP[7:2]
    logic [1:0]  cause_ip_sw_reg;   // IP[1:0]
    logic [4:0]  cause_exc_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;
    logic        flush_reg;
    logic [31:0] exc_pc_reg;

    logic [31:0] timer_count, timer_compare;
    logic        timer_ti;

    except_pipe_t except_in;
    exc_info_t    exc_info;
    logic         exc_commit, eret_commit, wr_en;
    logic [31:0]  cause_val, status_wr_val, cause_wr_val;
    logic [5:0]   ip_hw_next;

    assign except_in   = except_pipe_t'(WB_ExceptType);
    assign exc_info    = exc_decode(except_in);
    assign exc_commit  = |(WB_ExceptType & ~EXC_TYPE_ERET);
    assign eret_commit = (WB_ExceptType == EXC_TYPE_ERET);
    // An exception in the same WB slot suppresses the MTC0.
    assign wr_en       = WB_CP0Wr & ~exc_commit;

    // IP[7:2] mirror the hardware lines; the timer shares IP7 with ext_int[5].
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_ip_hw
            assign ip_hw_next[gi] = ext_int[gi];
        end
    endgenerate
    assign ip_hw_next[5] = ext_int[5] | timer_ti;

    assign cause_val = {cause_bd_reg, timer_ti, 14'b0, cause_ip_hw_reg,
                        cause_ip_sw_reg, 1'b0, cause_exc_reg, 2'b0};
    assign status_wr_val = (status_reg & ~STATUS_WMASK) | (WB_Result & STATUS_WMASK);
    assign cause_wr_val  = (cause_val & ~CAUSE_WMASK) | (WB_Result & CAUSE_WMASK);

    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (WB_Dst),
        .wr_data (WB_Result),
        .count   (timer_count),
        .compare (timer_compare),
        .ti      (timer_ti)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg      <= STATUS_RESET;
            cause_bd_reg    <= 1'b0;
            cause_ip_hw_reg <= '0;
            cause_ip_sw_reg <= '0;
            cause_exc_reg   <= '0;
            epc_reg         <= '0;
            badvaddr_reg    <= '0;
            flush_reg       <= 1'b0;
            exc_pc_reg      <= '0;
        end else begin
            cause_ip_hw_reg <= ip_hw_next;
            flush_reg       <= exc_commit | eret_commit;
            if (exc_commit) begin
                // Nested exceptions keep the original EPC/BD.
                if (!status_reg[STATUS_EXL]) begin
                    epc_reg      <= WB_IsInDelaySlot ? WB_PC - 32'd4 : WB_PC;
                    cause_bd_reg <= WB_IsInDelaySlot;
                end
                status_reg[STATUS_EXL] <= 1'b1;
                cause_exc_reg <= exc_info.code;
                if (exc_info.bv_from_pc)
                    badvaddr_reg <= WB_PC;
                else if (exc_info.bv_from_alu)
                    badvaddr_reg <= WB_ALUOut;
                exc_pc_reg <= (exc_info.refill && !status_reg[STATUS_EXL])
                              ? REFILL_VECTOR : EXC_VECTOR;
            end else if (eret_commit) begin
                status_reg[STATUS_EXL] <= 1'b0;
                exc_pc_reg <= epc_reg;
            end else if (wr_en) begin
                case (WB_Dst)
                    CP0_STATUS: status_reg      <= status_wr_val;
                    CP0_CAUSE:  cause_ip_sw_reg <= WB_Result[9:8];
                    CP0_EPC:    epc_reg         <= WB_Result;
                    default: ;
                endcase
            end
        end
    end

    // MFC0 read with same-cycle MTC0 bypass.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_BADVADDR: rd_data = badvaddr_reg;
            CP0_COUNT:    rd_data = timer_count;
            CP0_COMPARE:  rd_data = timer_compare;
            CP0_STATUS:   rd_data = status_reg;
            CP0_CAUSE:    rd_data = cause_val;
            CP0_EPC:      rd_data = epc_reg;
            default:      rd_data = '0;
        endcase
        if (wr_en && WB_Dst == rd_addr) begin
            case (rd_addr)
                CP0_COUNT, CP0_COMPARE, CP0_EPC: rd_data = WB_Result;
                CP0_STATUS: rd_data = status_wr_val;
                CP0_CAUSE:  rd_data = cause_wr_val;
                default: ;
            endcase
        end
    end

    assign cp0_int_req = status_reg[STATUS_IE] & ~status_reg[STATUS_EXL]
                       & |(cause_val[15:8] & status_reg[15:8]);
    assign exc_flush   = flush_reg;
    assign exc_pc      = exc_pc_reg;
    assign cp0_status  = status_reg;
    assign cp0_cause   = cause_val;
    assign cp0_epc     = epc_reg;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: one task per scenario, each comparing outputs
// against hand-computed values.
module tb_cp0_reg;
    import cp0_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_CP0Wr;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_Result;
    logic [11:0] WB_ExceptType;
    logic [31:0] WB_PC;
    logic        WB_IsInDelaySlot;
    logic [31:0] WB_ALUOut;
    logic [5:0]  ext_int;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        cp0_int_req;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk              (clk),
        .rst              (rst),
        .WB_CP0Wr         (WB_CP0Wr),
        .WB_Dst           (WB_Dst),
        .WB_Result        (WB_Result),
        .WB_ExceptType    (WB_ExceptType),
        .WB_PC            (WB_PC),
        .WB_IsInDelaySlot (WB_IsInDelaySlot),
        .WB_ALUOut        (WB_ALUOut),
        .ext_int          (ext_int),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .cp0_int_req      (cp0_int_req),
        .exc_flush        (exc_flush),
        .exc_pc           (exc_pc),
        .cp0_status       (cp0_status),
        .cp0_cause        (cp0_cause),
        .cp0_epc          (cp0_epc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        WB_CP0Wr         = 1'b0;
        WB_Dst           = '0;
        WB_Result        = '0;
        WB_ExceptType    = '0;
        WB_PC            = '0;
        WB_IsInDelaySlot = 1'b0;
        WB_ALUOut        = '0;
    endtask

    task automatic test_reset();
        clr_wb();
        ext_int = '0;
        rd_addr = CP0_COUNT;
        rst = 1'b1;
        step();
        step();
        n_vec++; if (cp0_status !== 32'h0040_0000) begin n_err++; $display("FAIL reset_status got %h exp %h", cp0_status, 32'h0040_0000); end
        n_vec++; if (cp0_cause !== 32'h0) begin n_err++; $display("FAIL reset_cause got %h exp 0", cp0_cause); end
        n_vec++; if (cp0_epc !== 32'h0) begin n_err++; $display("FAIL reset_epc got %h exp 0", cp0_epc); end
        n_vec++; if (exc_flush !== 1'b0 || exc_pc !== 32'h0) begin n_err++; $display("FAIL reset_flush got %b/%h exp 0/0", exc_flush, exc_pc); end
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_count got %h exp 0", rd_data); end
        rd_addr = CP0_BADVADDR;
        #1;
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_badvaddr got %h exp 0", rd_data); end
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_status_write();
        WB_CP0Wr = 1'b1; WB_Dst = CP0_STATUS; WB_Result = 32'hFFFF_FFFF; rd_addr = CP0_STATUS;
        #1;
        n_vec++; if (rd_data !== 32'h0040_FF03) begin n_err++; $display("FAIL status_bypass got %h exp %h", rd_data, 32'h0040_FF03); end
        step();
        clr_wb();
        #1;
        n_vec++; if (cp0_status !== 32'h0040_FF03) begin n_err++; $display("FAIL status_reg got %h exp %h", cp0_status, 32'h0040_FF03); end
        n_vec++; if (rd_data !== 32'h0040_FF03) begin n_err++; $display("FAIL status_read got %h exp %h", rd_data, 32'h0040_FF03); end
        // Unimplemented register: write ignored, reads zero.
        WB_CP0Wr = 1'b1; WB_Dst = 5'd5; WB_Result = 32'hFFFF_FFFF; rd_addr = 5'd5;
        #1;
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h exp 0", rd_data); end
        step();
        // Leave EXL=0, IE=1 for the exception tests.
        WB_CP0Wr = 1'b1; WB_Dst = CP0_STATUS; WB_Result = 32'h0000_FF01;
        step();
        clr_wb();
        n_vec++; if (cp0_status !== 32'h0040_FF01) begin n_err++; $display("FAIL status_reg2 got %h exp %h", cp0_status, 32'h0040_FF01); end
        $display("test_status_write: done");
    endtask

    task automatic test_overflow();
        except_pipe_t e;
        e = '0; e.overflow = 1'b1;
        WB_ExceptType = e; WB_PC = 32'h8000_1004; WB_IsInDelaySlot = 1'b1;
        step();
        clr_wb();
        n_vec++; if (exc_flush !== 1'b1 || exc_pc !== 32'hBFC0_0380) begin n_err++; $display("FAIL ov_redirect got %b/%h exp 1/bfc00380", exc_flush, exc_pc); end
        n_vec++; if (cp0_epc !== 32'h8000_1000) begin n_err++; $display("FAIL ov_epc got %h exp 80001000", cp0_epc); end
        n_vec++; if (cp0_cause[31] !== 1'b1 || cp0_cause[6:2] !== 5'h0C) begin n_err++; $display("FAIL ov_cause got %h exp BD=1 code=0c", cp0_cause); end
        n_vec++; if (cp0_status[1] !== 1'b1) begin n_err++; $display("FAIL ov_exl got %b exp 1", cp0_status[1]); end
        step();
        n_vec++; if (exc_flush !== 1'b0) begin n_err++; $display("FAIL ov_flush_pulse got %b exp 0", exc_flush); end
        $display("test_overflow: done");
    endtask

    task automatic test_eret(input logic [31:0] exp_pc);
        WB_ExceptType = EXC_TYPE_ERET;
        step();
        clr_wb();
        n_vec++; if (exc_flush !== 1'b1 || exc_pc !== exp_pc) begin n_err++; $display("FAIL eret_redirect got %b/%h exp 1/%h", exc_flush, exc_pc, exp_pc); end
        n_vec++; if (cp0_status[1] !== 1'b0) begin n_err++; $display("FAIL eret_exl got %b exp 0", cp0_status[1]); end
        step();
        n_vec++; if (exc_flush !== 1'b0) begin n_err++; $display("FAIL eret_flush_pulse got %b exp 0", exc_flush); end
        $display("test_eret: done exc_pc expected %h", exp_pc);
    endtask

    task automatic test_timer();
        WB_CP0Wr = 1'b1; WB_Dst = CP0_COUNT; WB_Result = 32'h0;
        step();
        WB_Dst = CP0_COMPARE; WB_Result = 32'd10;
        step();
        n_vec++; if (cp0_cause[30] !== 1'b0) begin n_err++; $display("FAIL timer_ti_clear0 got %b exp 0", cp0_cause[30]); end
        WB_Dst = CP0_STATUS; WB_Result = 32'h0040_8001;
        step();
        clr_wb();
        rd_addr = CP0_COMPARE;
        #1;
        n_vec++; if (rd_data !== 32'd10) begin n_err++; $display("FAIL timer_compare got %h exp 0000000a", rd_data); end
        for (int i = 0; i < 25; i++) step();
        n_vec++; if (cp0_cause[30] !== 1'b1 || cp0_cause[15] !== 1'b1) begin n_err++; $display("FAIL timer_ti_ip7 got %h exp TI=1 IP7=1", cp0_cause); end
        n_vec++; if (cp0_int_req !== 1'b1) begin n_err++; $display("FAIL timer_int_req got %b exp 1", cp0_int_req); end
        WB_CP0Wr = 1'b1; WB_Dst = CP0_COMPARE; WB_Result = 32'h0000_1000;
        step();
        clr_wb();
        n_vec++; if (cp0_cause[30] !== 1'b0) begin n_err++; $display("FAIL timer_ti_clear got %b exp 0", cp0_cause[30]); end
        step();
        n_vec++; if (cp0_cause[15] !== 1'b0 || cp0_int_req !== 1'b0) begin n_err++; $display("FAIL timer_ip7_clear got ip7=%b req=%b exp 0/0", cp0_cause[15], cp0_int_req); end
        $display("test_timer: done");
    endtask

    task automatic test_ext_int();
        ext_int = 6'h01;
        step();
        n_vec++; if (cp0_cause[10] !== 1'b1 || cp0_int_req !== 1'b0) begin n_err++; $display("FAIL ext_ip2 got ip2=%b req=%b exp 1/0", cp0_cause[10], cp0_int_req); end
        ext_int = 6'h20;
        step();
        n_vec++; if (cp0_cause[15:10] !== 6'b100000 || cp0_int_req !== 1'b1) begin n_err++; $display("FAIL ext_ip7 got ip=%b req=%b exp 100000/1", cp0_cause[15:10], cp0_int_req); end
        ext_int = 6'h00;
        step();
        $display("test_ext_int: done");
    endtask

    task automatic test_data_addr();
        except_pipe_t e;
        e = '0; e.rd_wrong_addr_mem = 1'b1;
        WB_ExceptType = e; WB_ALUOut = 32'h0000_0003; WB_PC = 32'h8000_2000;
        WB_CP0Wr = 1'b1; WB_Dst = CP0_EPC; WB_Result = 32'hDEAD_BEEF; rd_addr = CP0_EPC;
        #1;
        n_vec++; if (rd_data !== 32'h8000_1000) begin n_err++; $display("FAIL dataaddr_no_bypass got %h exp 80001000", rd_data); end
        step();
        clr_wb();
        rd_addr = CP0_BADVADDR;
        #1;
        n_vec++; if (rd_data !== 32'h3) begin n_err++; $display("FAIL dataaddr_badvaddr got %h exp 3", rd_data); end
        n_vec++; if (cp0_cause[6:2] !== 5'h04) begin n_err++; $display("FAIL dataaddr_code got %h exp 04", cp0_cause[6:2]); end
        n_vec++; if (cp0_epc !== 32'h8000_2000) begin n_err++; $display("FAIL dataaddr_epc got %h exp 80002000", cp0_epc); end
        n_vec++; if (exc_flush !== 1'b1 || exc_pc !== 32'hBFC0_0380) begin n_err++; $display("FAIL dataaddr_redirect got %b/%h exp 1/bfc00380", exc_flush, exc_pc); end
        step();
        $display("test_data_addr: done");
    endtask

    task automatic test_tlb_refill();
        except_pipe_t e;
        e = '0; e.tlb_refill = 1'b1;
        WB_ExceptType = e; WB_PC = 32'h8000_3008; WB_ALUOut = 32'h1234_5000;
        step();
        clr_wb();
        rd_addr = CP0_BADVADDR;
        #1;
        n_vec++; if (exc_flush !== 1'b1 || exc_pc !== 32'hBFC0_0200) begin n_err++; $display("FAIL refill1_redirect got %b/%h exp 1/bfc00200", exc_flush, exc_pc); end
        n_vec++; if (cp0_epc !== 32'h8000_3008 || rd_data !== 32'h1234_5000) begin n_err++; $display("FAIL refill1_state got epc=%h bva=%h exp 80003008/12345000", cp0_epc, rd_data); end
        n_vec++; if (cp0_cause[6:2] !== 5'h02) begin n_err++; $display("FAIL refill1_code got %h exp 02", cp0_cause[6:2]); end
        WB_ExceptType = e; WB_PC = 32'h8000_4000; WB_ALUOut = 32'h5555_0000;
        step();
        clr_wb();
        #1;
        n_vec++; if (exc_flush !== 1'b1 || exc_pc !== 32'hBFC0_0380) begin n_err++; $display("FAIL refill2_redirect got %b/%h exp 1/bfc00380", exc_flush, exc_pc); end
        n_vec++; if (cp0_epc !== 32'h8000_3008 || rd_data !== 32'h5555_0000) begin n_err++; $display("FAIL refill2_state got epc=%h bva=%h exp 80003008/55550000", cp0_epc, rd_data); end
        step();
        $display("test_tlb_refill: done");
    endtask

    task automatic test_priority();
        except_pipe_t e;
        e = '0; e.syscall = 1'b1; e.brk = 1'b1; e.tlb_modified = 1'b1;
        WB_ExceptType = e; WB_ALUOut = 32'hAAAA_0000; WB_PC = 32'h8000_5000;
        step();
        clr_wb();
        rd_addr = CP0_BADVADDR;
        #1;
        n_vec++; if (cp0_cause[6:2] !== 5'h08 || rd_data !== 32'h5555_0000) begin n_err++; $display("FAIL prio_sys got code=%h bva=%h exp 08/55550000", cp0_cause[6:2], rd_data); end
        e = '0; e.interrupt = 1'b1; e.overflow = 1'b1;
        WB_ExceptType = e;
        step();
        clr_wb();
        n_vec++; if (cp0_cause[6:2] !== 5'h00 || cp0_epc !== 32'h8000_3008) begin n_err++; $display("FAIL prio_int got code=%h epc=%h exp 00/80003008", cp0_cause[6:2], cp0_epc); end
        $display("test_priority: done");
    endtask

    task automatic test_reset_midflight();
        except_pipe_t e;
        e = '0; e.overflow = 1'b1;
        WB_ExceptType = e; WB_PC = 32'h8000_6000;
        rst = 1'b1;
        step();
        clr_wb();
        n_vec++; if (exc_flush !== 1'b0 || cp0_status !== 32'h0040_0000 || cp0_epc !== 32'h0) begin n_err++; $display("FAIL midreset got flush=%b st=%h epc=%h exp 0/00400000/0", exc_flush, cp0_status, cp0_epc); end
        rst = 1'b0;
        step();
        n_vec++; if (exc_flush !== 1'b0) begin n_err++; $display("FAIL midreset_flush got %b exp 0", exc_flush); end
        $display("test_reset_midflight: done");
    endtask

    initial begin
        test_reset();
        test_status_write();
        test_overflow();
        test_eret(32'h8000_1000);
        test_timer();
        test_ext_int();
        test_data_addr();
        test_eret(32'h8000_2000);
        test_tlb_refill();
        test_priority();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file and precise-exception commit unit.
- Consumes the WB_CP0 stage signals and serves MFC0 reads from MEM.
- Owns BadVAddr, Count, Compare, Status, Cause and EPC.
- Produces the interrupt request sampled by the pipeline, and a registered flush plus redirect PC for exceptions and ERET.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception vector (BEV fixed 1).
- REFILL_VECTOR, 32'hBFC0_0200, TLB refill vector, used when Status.EXL=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- WB_CP0Wr  in  1  MTC0 commit
- WB_Dst  in  5  CP0 register number for MTC0
- WB_Result  in  32  MTC0 write data
- WB_ExceptType  in  12  ExceptinPipeType of the committing instruction
- WB_PC  in  32  committing instruction PC
- WB_IsInDelaySlot  in  1  committing instruction is in a delay slot
- WB_ALUOut  in  32  data address for memory/TLB faults
- ext_int  in  6  hardware interrupt lines, level-sensitive
- rd_addr  in  5  MFC0 read register number
- rd_data  out  32  MFC0 read data (combinational)
- cp0_int_req  out  1  enabled pending interrupt
- exc_flush  out  1  one-cycle pipeline flush
- exc_pc  out  32  redirect target, valid while exc_flush=1
- cp0_status  out  32  Status register
- cp0_cause  out  32  Cause register
- cp0_epc  out  32  EPC register

Behaviour:
- Reset values:
  - Status=32'h0040_0000 (BEV=1).
  - Cause, EPC, Count, Compare and BadVAddr all 0.
  - exc_flush=0, exc_pc=0, internal tick=0.
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other number reads 0 and ignores writes.
- Write masks:
  - Status: writable bits IM[15:8], EXL[1], IE[0].
  - Cause: writable bits IP[9:8].
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr: read-only.
- Timer:
  - tick toggles every cycle; Count increments (wraps at 2^32) when tick=1.
  - Cause.TI sets when Count==Compare and stays set until a Compare write clears it.
  - An MTC0 to Count or Compare overrides the increment or match in the same cycle.
- Cause.IP[7:2] is resampled every cycle as {ext_int[5]|TI, ext_int[4:0]}.
- cp0_int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). It is combinational from the registers.
- Exception commit (any WB_ExceptType bit except Eret):
  - ExcCode priority, highest first: Interrupt 0x00 > WrongAddressinIF 0x04 > ReservedInstruction 0x0A > Overflow 0x0C > Syscall 0x08 > Break 0x09 > RdWrongAddressinMEM 0x04 > WrWrongAddressinMEM 0x05 > TLBRefill 0x02 > TLBInvalid 0x02 > TLBModified 0x01.
  - If EXL=0: EPC = BD ? WB_PC-4 : WB_PC, and Cause.BD = WB_IsInDelaySlot.
  - If EXL=1: EPC and BD are unchanged.
  - EXL is set to 1.
  - BadVAddr = WB_PC for an IF address error; WB_ALUOut for a data address error or any TLB fault; otherwise unchanged.
- Eret (Eret bit is the only bit set): EXL cleared; redirect target = EPC.
- Redirect is registered, latency 1:
  - The cycle after commit: exc_flush=1 for exactly one cycle.
  - exc_pc = REFILL_VECTOR for TLBRefill with prior EXL=0; EXC_VECTOR for other exceptions; pre-commit EPC for Eret.
- Simultaneous events:
  - Exception and WB_CP0Wr in the same cycle: the exception wins and the write is dropped.
  - Eret and an MTC0 to EPC in the same cycle cannot occur (single WB slot).
- Read bypass: if WB_CP0Wr=1, WB_Dst==rd_addr and no exception is committing, rd_data returns the masked write value; otherwise it returns the register value.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and a pending flush is cancelled.

Decomposition:
- Shared package (CPU_Defines/CommonDefines):
  - CP0 register numbers.
  - ExcCode constants.
  - Status and Cause bit positions.
  - Vector addresses.
  - Reuse ExceptinPipeType.
- Sub-module cp0_timer: owns tick, Count, Compare and TI, plus the write/clear arbitration for those registers.

Test Plan:
- Reset, then MTC0 12 ← 32'hFFFF_FFFF → Status reads 32'h0040_FF03; MFC0 in the same cycle returns 32'h0040_FF03 via the bypass.
- Overflow at PC 0x8000_1004 with BD=1 → next cycle exc_flush=1, exc_pc=0xBFC0_0380; EPC=0x8000_1000, Cause.BD=1, ExcCode=0x0C, EXL=1.
- Eret after the previous case → next cycle exc_flush=1, exc_pc=0x8000_1000; EXL=0.
- Compare=10, Count=0, Status=0x0040_8001 → TI and IP7 set after 20 cycles and cp0_int_req=1; MTC0 Compare clears TI.
- RdWrongAddressinMEM with WB_ALUOut=0x0000_0003 → BadVAddr=3, ExcCode=0x04; a simultaneous MTC0 to EPC is dropped.
- TLBRefill with EXL=0 → exc_pc=0xBFC0_0200. A second TLBRefill while EXL=1 → exc_pc=0xBFC0_0380 and EPC unchanged.
